scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 15 +
 rtl/next_pos_find.sv | 29 ++
 rtl/scan_sequencer.sv | 144 ++++++++++++++
 tb/tb_scan_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer.
//   state_e : FSM encoding (IDLE = 0, SCAN = 1)
//   POS_W   : width of a scan position (3 bits -> 8 positions)
//   NUM_POS : number of scan positions (width of the mask)
package scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int POS_W   = 3;
  localparam int NUM_POS = 8;

endpackage

// File: rtl/next_pos_find.sv
// Combinational next-set-bit search over the scan mask.
//   mask        : in  - enabled positions, bit i = position i
//   pos         : in  - current position (ignored when from_lowest = 1)
//   from_lowest : in  - 1 = return the lowest set bit, 0 = lowest set bit above pos
//   next_pos    : out - selected position (0 when nothing found)
//   found       : out - a qualifying set bit exists
module next_pos_find
  import scan_pkg::*;
(
  input  logic [NUM_POS-1:0] mask,
  input  logic [POS_W-1:0]   pos,
  input  logic               from_lowest,
  output logic [POS_W-1:0]   next_pos,
  output logic               found
);

  // Scan from the top down so the lowest qualifying bit is the last writer.
  always_comb begin
    next_pos = '0;
    found    = 1'b0;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (mask[i] && (from_lowest || (POS_W'(i) > pos))) begin
        next_pos = POS_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit position through the enabled mask bits,
// holding each for max(DWELL,1) cycles, single sweep or continuous.
//   CLK, RST        : clock, synchronous active-high reset
//   START, STOP     : one-cycle begin / abort requests (STOP wins)
//   CONT            : 1 = wrap continuously, 0 = single sweep
//   MASK, DWELL     : enabled positions and dwell length, latched on START
//   EN, BUSY        : high while scanning (decoder enable)
//   W2, W1, W0      : position select, W2 = MSB, held while idle
//   DONE            : one-cycle pulse at the end of a single sweep
//   dbg_state       : current FSM state (0 = IDLE, 1 = SCAN)
// Handshake: START/STOP are single-cycle strobes sampled on the rising edge;
// START is accepted only in IDLE, STOP only acts in SCAN. All outputs are
// registered, so responses appear one cycle after the sampling edge.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               CONT,
  input  logic [NUM_POS-1:0] MASK,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               EN,
  output logic               W2,
  output logic               W1,
  output logic               W0,
  output logic               BUSY,
  output logic               DONE,
  output logic               dbg_state
);

  state_e               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [NUM_POS-1:0]   mask_q, mask_d;
  logic                 cont_q, cont_d;
  logic                 done_q, done_d;

  logic [POS_W-1:0]     nxt_pos, first_pos;
  logic                 nxt_found, first_found;
  logic [NUM_POS-1:0]   first_mask;
  logic                 dwell_last;

  // Next higher enabled position within the latched mask.
  next_pos_find u_next (
    .mask        (mask_q),
    .pos         (pos_q),
    .from_lowest (1'b0),
    .next_pos    (nxt_pos),
    .found       (nxt_found)
  );

  // Lowest enabled position: taken from the live MASK when starting and from
  // the latched mask when wrapping.
  assign first_mask = (state_q == IDLE) ? MASK : mask_q;

  next_pos_find u_first (
    .mask        (first_mask),
    .pos         (pos_q),
    .from_lowest (1'b1),
    .next_pos    (first_pos),
    .found       (first_found)
  );

  // cnt_q counts cycles already spent at the position; DWELL of 0 or 1 both
  // mean a single cycle.
  assign dwell_last = (dwell_q <= DWELL_W'(1)) || (cnt_q == dwell_q - DWELL_W'(1));

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          mask_d  = MASK;
          dwell_d = DWELL;
          cont_d  = CONT;
          cnt_d   = '0;
          if (first_found) begin
            state_d = SCAN;
            pos_d   = first_pos;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (STOP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dwell_last) begin
          cnt_d = '0;
          if (nxt_found) begin
            pos_d = nxt_pos;
          end else if (cont_q) begin
            pos_d = first_pos;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end

  assign EN           = (state_q == SCAN);
  assign BUSY         = (state_q == SCAN);
  assign {W2, W1, W0} = pos_q;
  assign DONE         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer: directed vector table followed by random
// stimulus, both checked against a position-list reference model.
module tb_scan_sequencer;

  logic       CLK;
  logic       RST, START, STOP, CONT;
  logic [7:0] MASK, DWELL;
  logic       EN, W2, W1, W0, BUSY, DONE, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .STOP      (STOP),
    .CONT      (CONT),
    .MASK      (MASK),
    .DWELL     (DWELL),
    .EN        (EN),
    .W2        (W2),
    .W1        (W1),
    .W0        (W0),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Scan is described as a list of enabled positions walked by index, with a
  // countdown of remaining cycles at the current entry.
  int m_list[$];
  int m_idx, m_left, m_hold, m_pos;
  bit m_busy, m_done, m_cont;

  task automatic model_step();
    if (RST) begin
      m_busy = 0; m_done = 0; m_pos = 0; m_cont = 0; m_hold = 1;
      m_list.delete();
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (STOP) begin
          m_busy = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_idx++;
            if (m_idx >= m_list.size()) begin
              if (m_cont) m_idx = 0;
              else begin m_busy = 0; m_done = 1; end
            end
            if (m_busy) begin
              m_pos  = m_list[m_idx];
              m_left = m_hold;
            end
          end
        end
      end else if (START && !STOP) begin
        m_list.delete();
        for (int i = 0; i < 8; i++) if (MASK[i]) m_list.push_back(i);
        m_hold = (DWELL == 0) ? 1 : int'(DWELL);
        m_cont = CONT;
        if (m_list.size() == 0) m_done = 1;
        else begin
          m_busy = 1; m_idx = 0; m_pos = m_list[0]; m_left = m_hold;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  function automatic logic [6:0] pack_out(bit en, bit [2:0] w, bit done);
    return {en, en, en, w, done};
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {en,busy,st,w,done}=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] exp_q[$];

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic cycle(string tag);
    logic [6:0] act;
    @(posedge CLK);
    model_step();
    exp_q.push_back(pack_out(m_busy, 3'(m_pos), m_done));
    #1;
    act = {EN, BUSY, dbg_state, W2, W1, W0, DONE};
    check({"model_", tag}, act, exp_q.pop_front());
  endtask

  task automatic drive(bit rst, bit start, bit stop, bit cont, logic [7:0] mask, logic [7:0] dwell);
    RST = rst; START = start; STOP = stop; CONT = cont; MASK = mask; DWELL = dwell;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst, start, stop, cont;
    logic [7:0] mask, dwell;
    bit         en;
    logic [2:0] w;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit start, bit stop, bit cont, logic [7:0] mask,
                              logic [7:0] dwell, bit en, logic [2:0] w, bit done);
    vec_t v;
    v.rst = rst; v.start = start; v.stop = stop; v.cont = cont;
    v.mask = mask; v.dwell = dwell; v.en = en; v.w = w; v.done = done;
    tbl.push_back(v);
  endfunction

  function automatic void nop(bit en, logic [2:0] w, bit done);
    add(0, 0, 0, 0, 8'h00, 8'h00, en, w, done);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    #2;

    // Reset state
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0);
    nop(0, 3'd0, 0);
    // Full mask, dwell 1, single sweep: 0..7 then DONE
    add(0, 1, 0, 0, 8'hFF, 8'd1, 1, 3'd0, 0);
    for (int p = 1; p < 8; p++) nop(1, 3'(p), 0);
    nop(0, 3'd7, 1);
    nop(0, 3'd7, 0);
    // Mask 10100100, dwell 3, continuous, STOP in 2nd cycle of position 5
    add(0, 1, 0, 1, 8'hA4, 8'd3, 1, 3'd2, 0);
    nop(1, 3'd2, 0); nop(1, 3'd2, 0);
    nop(1, 3'd5, 0); nop(1, 3'd5, 0); nop(1, 3'd5, 0);
    nop(1, 3'd7, 0); nop(1, 3'd7, 0); nop(1, 3'd7, 0);
    nop(1, 3'd2, 0); nop(1, 3'd2, 0); nop(1, 3'd2, 0);
    nop(1, 3'd5, 0); nop(1, 3'd5, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 0, 3'd5, 0);
    nop(0, 3'd5, 0);
    // Empty mask: DONE pulse only, position held
    add(0, 1, 0, 0, 8'h00, 8'd4, 0, 3'd5, 1);
    nop(0, 3'd5, 0);
    // Dwell 0 behaves as 1
    add(0, 1, 0, 0, 8'h03, 8'd0, 1, 3'd0, 0);
    nop(1, 3'd1, 0);
    nop(0, 3'd1, 1);
    nop(0, 3'd1, 0);
    // START with STOP in IDLE: nothing
    add(0, 1, 1, 1, 8'hFF, 8'd1, 0, 3'd1, 0);
    nop(0, 3'd1, 0);
    // Mid-scan MASK change and START are ignored
    add(0, 1, 0, 0, 8'h06, 8'd2, 1, 3'd1, 0);
    add(0, 1, 0, 1, 8'h00, 8'd1, 1, 3'd1, 0);
    add(0, 0, 0, 1, 8'h00, 8'd1, 1, 3'd2, 0);
    nop(1, 3'd2, 0);
    nop(0, 3'd2, 1);
    nop(0, 3'd2, 0);
    // Single bit continuous holds, then reset at position 4
    add(0, 1, 0, 1, 8'h10, 8'd5, 1, 3'd4, 0);
    for (int k = 0; k < 7; k++) nop(1, 3'd4, 0);
    add(1, 1, 1, 0, 8'hFF, 8'd1, 0, 3'd0, 0);
    nop(0, 3'd0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].cont, tbl[i].mask, tbl[i].dwell);
      cycle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d", i), {EN, BUSY, dbg_state, W2, W1, W0, DONE},
            pack_out(tbl[i].en, tbl[i].w, tbl[i].done));
    end

    // ---------------- random stimulus ----------------
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] mk;
      case ($urandom_range(0, 3))
        0:       mk = 8'h00;
        1:       mk = 8'h01 << $urandom_range(0, 7);
        default: mk = 8'($urandom_range(0, 255));
      endcase
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)),
            mk,
            8'($urandom_range(0, 4)));
      cycle($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
